wb_arbiter2: RTL and testbench

// - Shares one pipelined Wishbone B4 bus between two masters, upstream of wb_intercon.
// - m0 is the J1 CPU; m1 is a secondary master (DMA / debug loader).
// - Round-robin grant, held for the owner's whole cycle (cyc high).
// - Outstanding-transfer tracking: stall limiting, ack routing and optional watchdog.

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/if_wb.sv | 21 ++
 rtl/wb_arb_watchdog.sv | 34 +++
 rtl/wb_arbiter2.sv | 166 ++++++++++++++++
 tb/tb_wb_arbiter2.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//   Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t  : arbiter FSM encoding (IDLE, OWN0, OWN1)
//   ADR_W, DAT_W : Wishbone address / data widths
//   TIMEOUT_DAT  : read data returned with a watchdog-generated ack
package wb_arb_pkg;

  localparam int ADR_W = 16;
  localparam int DAT_W = 16;
  localparam logic [DAT_W-1:0] TIMEOUT_DAT = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/if_wb.sv
// if_wb
//   Pipelined Wishbone B4 bundle. Signal names are seen from the master side:
//   dat_o is write data (master -> slave) and dat_i is read data (slave -> master).
//   modport master : drives adr/dat_o/we/cyc/stb, receives dat_i/stall/ack
//   modport slave  : the mirror image
interface if_wb;
  import wb_arb_pkg::*;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;
  logic             we;
  logic             cyc;
  logic             stb;
  logic             stall;
  logic             ack;

  modport master (output adr, dat_o, we, cyc, stb, input dat_i, stall, ack);
  modport slave  (input adr, dat_o, we, cyc, stb, output dat_i, stall, ack);

endinterface

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog
//   Counts cycles spent waiting for an ack while transfers are outstanding and
//   raises a one-cycle fire pulse after TIMEOUT silent cycles.
//   clk, rst : clock, asynchronous active-high reset
//   run      : at least one transfer outstanding
//   ack      : real ack seen on the shared bus this cycle
//   fire     : watchdog expiry, suppressed when a real ack arrives the same cycle
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ack,
  output logic fire
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog;

  assign fire = run & ~ack & (wdog == WD_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (!run || ack || fire) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2
//   Round-robin arbiter sharing one pipelined Wishbone B4 bus between master 0
//   (CPU) and master 1 (DMA / debug loader). Ownership is held for the whole
//   cyc of the owner; accepted-but-unacked strobes are counted to limit the
//   pipeline depth and to drop acks that no longer belong to anyone.
//   clk, rst : clock, asynchronous active-high reset
//   m0, m1   : master ports (m0 wins the first tie after reset)
//   s        : shared bus towards the interconnect
//   gnt      : one-hot current owner, 2'b00 when idle or releasing
//   timeout  : one-cycle pulse when the watchdog fires
//   Build option: define WB_ARB_TIMEOUT_EN to include the ack watchdog.
//
//   state | meaning
//   IDLE  | no owner, both masters stalled
//   OWN0  | master 0 owns the shared bus
//   OWN1  | master 1 owns the shared bus
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.master       s,
  output logic [1:0] gnt,
  output logic       timeout
);

  arb_state_t       state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             own_cyc, own_stb, own_we;
  logic [ADR_W-1:0] own_adr;
  logic [DAT_W-1:0] own_dat;
  logic [DAT_W-1:0] dat_fwd;
  logic owned, at_limit, owner_stall, cnt_nz, rel;
  logic accept, ack_real, ack_any, ack_fwd, fire;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    unique case (state)
      OWN0: begin
        own_cyc = m0.cyc; own_stb = m0.stb; own_we = m0.we;
        own_adr = m0.adr; own_dat = m0.dat_o;
      end
      OWN1: begin
        own_cyc = m1.cyc; own_stb = m1.stb; own_we = m1.we;
        own_adr = m1.adr; own_dat = m1.dat_o;
      end
      default: ;
    endcase
  end

  assign owned       = (state != IDLE);
  assign at_limit    = (cnt == CNT_W'(MAX_OUTST));
  assign owner_stall = s.stall | at_limit;
  assign cnt_nz      = (cnt != '0);
  assign rel         = owned & ~own_cyc;

  // The strobe is masked at the limit so the slave never accepts a transfer
  // that the owner was told is stalled.
  assign s.cyc   = own_cyc;
  assign s.stb   = own_cyc & own_stb & ~at_limit;
  assign s.we    = own_we;
  assign s.adr   = own_adr;
  assign s.dat_o = own_dat;

  assign accept   = s.stb & ~owner_stall;
  // An ack with nothing outstanding is stale (from a released or reset cycle).
  assign ack_real = owned & s.ack & cnt_nz;
  assign ack_any  = ack_real | fire;
  assign ack_fwd  = ack_any & own_cyc;
  assign dat_fwd  = fire ? TIMEOUT_DAT : s.dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .run  (cnt_nz),
    .ack  (s.ack),
    .fire (fire)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign fire = 1'b0;
`endif

  assign timeout = fire;
  // The releasing cycle reports no owner even though the state still names one.
  assign gnt = {(state == OWN1) & m1.cyc, (state == OWN0) & m0.cyc};

  always_comb begin
    m0.stall = 1'b1;
    m0.ack   = 1'b0;
    m0.dat_i = '0;
    m1.stall = 1'b1;
    m1.ack   = 1'b0;
    m1.dat_i = '0;
    if (state == OWN0) begin
      m0.stall = owner_stall;
      m0.ack   = ack_fwd;
      m0.dat_i = dat_fwd;
    end
    if (state == OWN1) begin
      m1.stall = owner_stall;
      m1.ack   = ack_fwd;
      m1.dat_i = dat_fwd;
    end
  end

  // last = 1 means master 1 owned most recently, so master 0 wins a tie.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_nxt = last ? OWN0 : OWN1;
        else if (m0.cyc)      state_nxt = OWN0;
        else if (m1.cyc)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0.cyc) begin
          last_nxt  = 1'b0;
          state_nxt = m1.cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1.cyc) begin
          last_nxt  = 1'b1;
          state_nxt = m0.cyc ? OWN0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (rel)                      cnt_nxt = '0;
    else if (accept && !ack_any)  cnt_nxt = cnt + 1'b1;
    else if (!accept && ack_any)  cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2
//   Directed bench for wb_arbiter2: a master model issues strobes and pushes the
//   expected read data to per-master scoreboards; a slave model acks accepted
//   strobes after a programmable latency; acks reaching the masters are popped
//   and compared.
module tb_wb_arbiter2;
  import wb_arb_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;
  logic       timeout;

  if_wb m0_bus ();
  if_wb m1_bus ();
  if_wb s_bus ();

  wb_arbiter2 #(.MAX_OUTST(4), .CNT_W(3), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus),
    .gnt     (gnt),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int cyc_n = 0;
  int due_q[$];
  logic [15:0] rsp_q[$];
  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];
  int todo0 = 0;
  int lat = 3;
  int acks0 = 0;
  int acks1 = 0;
  bit mute = 1'b0;
  bit slv_ack = 1'b0;
  logic [15:0] base0 = 16'h1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_masters();
    m0_bus.stb = m0_bus.cyc && (todo0 > 0);
    m0_bus.adr = base0 + 16'(todo0);
    m1_bus.stb = 1'b0;
  endtask

  // Called at the falling edge: everything is settled for the coming rising edge.
  task automatic sample_bus();
    if (slv_ack) begin
      due_q.delete(0);
      rsp_q.delete(0);
    end
    if (m0_bus.ack) begin
      chk("m0_ack_owed", 32'(exp0_q.size() != 0), 1);
      if (exp0_q.size() != 0) begin
        chk("m0_dat", 32'(m0_bus.dat_i), 32'(exp0_q.pop_front()));
        acks0++;
      end
    end
    if (m1_bus.ack) begin
      chk("m1_ack_owed", 32'(exp1_q.size() != 0), 1);
      if (exp1_q.size() != 0) begin
        chk("m1_dat", 32'(m1_bus.dat_i), 32'(exp1_q.pop_front()));
        acks1++;
      end
    end
    if (m0_bus.cyc && m0_bus.stb && !m0_bus.stall) begin
      exp0_q.push_back(mute ? 16'hDEAD : (m0_bus.adr ^ 16'hA5A5));
      todo0--;
    end
    if (s_bus.cyc && s_bus.stb && !s_bus.stall && !mute) begin
      due_q.push_back(cyc_n + lat);
      rsp_q.push_back(s_bus.adr ^ 16'hA5A5);
    end
  endtask

  task automatic drive_slave();
    slv_ack = (due_q.size() != 0) && (due_q[0] <= cyc_n);
    s_bus.ack   = slv_ack;
    s_bus.dat_i = slv_ack ? rsp_q[0] : 16'h0000;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_bus();
    @(posedge clk);
    #1;
    cyc_n++;
    drive_slave();
    drive_masters();
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    int n;
    int a0;
    bit any_ack;
    bit any_to;

    rst = 1'b1;
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
    m0_bus.adr = '0;   m0_bus.dat_o = '0;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
    m1_bus.adr = '0;   m1_bus.dat_o = '0;
    s_bus.stall = 1'b0; s_bus.ack = 1'b0; s_bus.dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    settle();

    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_m0_stall", 32'(m0_bus.stall), 1);
    chk("rst_m1_stall", 32'(m1_bus.stall), 1);
    chk("rst_s_cyc", 32'(s_bus.cyc), 0);
    chk("rst_m0_ack", 32'(m0_bus.ack), 0);
    chk("rst_m0_dat", 32'(m0_bus.dat_i), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cnt", 32'(dut.cnt), 0);

    // Tie straight out of reset: m0 wins, m1 waits.
    rst = 1'b0;
    m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1; drive_masters();
    #1;
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_m0_stall", 32'(m0_bus.stall), 1);
    cycle(); settle();
    chk("tie_gnt", 32'(gnt), 1);
    chk("tie_m0_stall", 32'(m0_bus.stall), 0);
    chk("tie_m1_stall", 32'(m1_bus.stall), 1);
    chk("tie_s_cyc", 32'(s_bus.cyc), 1);
    repeat (2) cycle();
    settle();
    chk("hold_gnt", 32'(gnt), 1);
    chk("hold_m1_stall", 32'(m1_bus.stall), 1);

    // m0 releases while m1 waits: one dead cycle then m1 owns.
    m0_bus.cyc = 1'b0; drive_masters();
    #1;
    chk("rel_gnt", 32'(gnt), 0);
    chk("rel_s_cyc", 32'(s_bus.cyc), 0);
    cycle(); settle();
    chk("handover_gnt", 32'(gnt), 2);
    chk("handover_m1_stall", 32'(m1_bus.stall), 0);
    chk("handover_s_cyc", 32'(s_bus.cyc), 1);

    // m1 releases; next tie goes to m0.
    m1_bus.cyc = 1'b0; drive_masters();
    cycle(); settle();
    chk("m1_rel_gnt", 32'(gnt), 0);
    m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1; drive_masters();
    cycle(); settle();
    chk("tie2_gnt", 32'(gnt), 1);

    // m0 releases last with nobody waiting; next tie goes to m1.
    m1_bus.cyc = 1'b0; drive_masters();
    cycle();
    m0_bus.cyc = 1'b0; drive_masters();
    cycle(); settle();
    chk("idle2_gnt", 32'(gnt), 0);
    m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1; drive_masters();
    cycle(); settle();
    chk("tie3_gnt", 32'(gnt), 2);
    m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0; drive_masters();
    repeat (2) cycle();

    // Six strobes against a slow slave: the fifth is held at the limit.
    lat = 4; a0 = acks0;
    m0_bus.cyc = 1'b1; todo0 = 6; drive_masters();
    n = 0;
    while (todo0 > 2 && n < 20) begin cycle(); n++; end
    settle();
    chk("burst_fill_bound", 32'(n < 20), 1);
    chk("burst_limit_stall", 32'(m0_bus.stall), 1);
    chk("burst_limit_cnt", 32'(dut.cnt), 4);
    chk("burst_limit_s_stb", 32'(s_bus.stb), 0);
    n = 0;
    while ((todo0 != 0 || exp0_q.size() != 0) && n < 40) begin cycle(); n++; end
    settle();
    chk("burst_drain_bound", 32'(n < 40), 1);
    chk("burst_acks", 32'(acks0 - a0), 6);
    chk("burst_cnt_zero", 32'(dut.cnt), 0);
    m0_bus.cyc = 1'b0; drive_masters();
    cycle();

    // Accept and ack in the same cycle at cnt=2; m1 waits and sees no ack.
    lat = 2;
    m0_bus.cyc = 1'b1; todo0 = 4; drive_masters();
    cycle();
    m1_bus.cyc = 1'b1; drive_masters();
    n = 0;
    while (todo0 > 0 && n < 20) begin cycle(); n++; end
    settle();
    chk("same_cycle_cnt", 32'(dut.cnt), 2);
    chk("m0_ack_routed", 32'(m0_bus.ack), 1);
    chk("m1_ack_blocked", 32'(m1_bus.ack), 0);
    chk("m1_waiting_stall", 32'(m1_bus.stall), 1);
    n = 0;
    while (exp0_q.size() != 0 && n < 20) begin cycle(); n++; end
    chk("same_cycle_drain_bound", 32'(n < 20), 1);
    m0_bus.cyc = 1'b0; drive_masters();
    cycle();
    m1_bus.cyc = 1'b0; drive_masters();
    cycle();

    // Reset mid-burst with three strobes in flight.
    lat = 6;
    m0_bus.cyc = 1'b1; todo0 = 5; drive_masters();
    n = 0;
    while (todo0 > 2 && n < 20) begin cycle(); n++; end
    settle();
    chk("pre_rst_cnt", 32'(dut.cnt), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_cnt", 32'(dut.cnt), 0);
    chk("mid_rst_s_cyc", 32'(s_bus.cyc), 0);
    chk("mid_rst_m0_stall", 32'(m0_bus.stall), 1);
    exp0_q.delete();
    todo0 = 0; drive_masters();
    cycle();
    rst = 1'b0;
    n = 0;
    while (!s_bus.ack && n < 12) begin cycle(); n++; end
    settle();
    chk("stray_seen", 32'(s_bus.ack), 1);
    chk("stray_gnt", 32'(gnt), 1);
    chk("stray_m0_ack", 32'(m0_bus.ack), 0);
    n = 0;
    while (due_q.size() != 0 && n < 12) begin cycle(); n++; end
    m0_bus.cyc = 1'b0; drive_masters();
    cycle();

    // Slave that never acks.
    mute = 1'b1;
    m0_bus.cyc = 1'b1; todo0 = 1; drive_masters();
    n = 0;
    while (todo0 > 0 && n < 10) begin cycle(); n++; end
`ifdef WB_ARB_TIMEOUT_EN
    n = 0;
    settle();
    while (!m0_bus.ack && n < 20) begin cycle(); settle(); n++; end
    chk("wd_latency", 32'(n), TO);
    chk("wd_pulse", 32'(timeout), 1);
    chk("wd_dat", 32'(m0_bus.dat_i), 32'hDEAD);
    cycle(); settle();
    chk("wd_pulse_end", 32'(timeout), 0);
    chk("wd_cnt", 32'(dut.cnt), 0);
`else
    any_ack = 1'b0;
    any_to  = 1'b0;
    for (int i = 0; i < 2 * TO; i++) begin
      cycle(); settle();
      any_ack |= m0_bus.ack;
      any_to  |= timeout;
    end
    chk("nowd_ack", 32'(any_ack), 0);
    chk("nowd_timeout", 32'(any_to), 0);
    chk("nowd_stall", 32'(m0_bus.stall), 0);
    chk("nowd_cnt", 32'(dut.cnt), 1);
`endif
    rst = 1'b1;
    mute = 1'b0;
    exp0_q.delete();
    m0_bus.cyc = 1'b0; drive_masters();
    #1;
    chk("final_rst_gnt", 32'(gnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
